// File: rtl/stats_unpacker_avlstrm.sv
// Stages the records of one stats frame and commits them atomically into a CSR register file.
// Commit writes one record per cycle; in_ready/rd_ready drop while a commit is in progress.
module stats_unpacker_avlstrm #(
   parameter int                ADDR_W       = 8,
   parameter int                VAL_W        = 32,
   parameter int                NUM_REGS     = 64,
   parameter int                MAX_FRAME    = 32,
   parameter logic [ADDR_W-1:0] NOTUSED_ADDR = 8'hFF
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [ADDR_W+VAL_W-1:0] in_data,
   input  logic                    in_valid,
   input  logic                    in_sop,
   input  logic                    in_eop,
   output logic                    in_ready,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic                    rd_ready,
   output logic                    rd_valid,
   output logic [VAL_W-1:0]        rd_data,
   output logic [31:0]             frame_count,
   output logic [31:0]             drop_count,
   output logic [31:0]             err_count
);

   localparam int IW = $clog2(NUM_REGS);
   localparam int CW = $clog2(MAX_FRAME + 1);
   localparam int PW = $clog2(MAX_FRAME);
   localparam logic [ADDR_W:0] LP_NREGS = ADDR_W'(NUM_REGS);
   localparam logic [CW-1:0]   LP_MAX   = CW'(MAX_FRAME);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, r_ptr;
   logic              r_ovf;
   logic [IW-1:0]     r_stage_idx [MAX_FRAME];
   logic [VAL_W-1:0]  r_stage_val [MAX_FRAME];
   logic [VAL_W-1:0]  r_regs      [NUM_REGS];
   logic [31:0]       r_frame_count, r_drop_count, r_err_count;
   logic              r_rd_valid;
   logic [VAL_W-1:0]  r_rd_data;

   logic [ADDR_W-1:0] w_addr;
   logic [VAL_W-1:0]  w_val;
   logic              w_acc, w_notused, w_bad, w_good;
   logic              w_take, w_start, w_drop, w_done, w_wr;
   logic [1:0]        w_err_inc;
   logic [CW-1:0]     w_base_cnt;
   logic              w_base_ovf, w_full, w_ovf_nxt, w_push;
   logic              w_rd_acc, w_rd_inrange;

   assign w_addr    = in_data[ADDR_W+VAL_W-1 -: ADDR_W];
   assign w_val     = in_data[VAL_W-1:0];
   assign w_acc     = in_valid & in_ready;
   assign w_notused = (w_addr == NOTUSED_ADDR);
   assign w_bad     = !w_notused && ({1'b0, w_addr} >= LP_NREGS);
   assign w_good    = !w_notused && !w_bad;

   // A sop beat restarts the frame, so the staging base is taken as empty.
   assign w_base_cnt = w_start ? '0 : r_cnt;
   assign w_base_ovf = w_start ? 1'b0 : r_ovf;
   assign w_full     = (w_base_cnt == LP_MAX);
   assign w_ovf_nxt  = w_base_ovf | (w_good & w_full);
   assign w_push     = w_take & w_good & !w_full;

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_start     = 1'b0;
      w_err_inc   = 2'd0;
      w_drop      = 1'b0;
      w_done      = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (w_acc) begin
               if (r_state == S_IDLE && !in_sop) begin
                  w_err_inc = 2'd1;
               end else begin
                  w_take  = 1'b1;
                  w_start = in_sop;
                  if (r_state == S_COLLECT && in_sop) w_err_inc = 2'd1;
                  if (w_bad) w_err_inc = w_err_inc + 2'd1;
                  if (in_eop) begin
                     if (w_ovf_nxt) begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_IDLE;
                     end else begin
                        w_state_nxt = S_COMMIT;
                     end
                  end else begin
                     w_state_nxt = S_COLLECT;
                  end
               end
            end
         end
         S_COMMIT: begin
            w_wr = (r_cnt != '0);
            if (r_cnt == '0 || r_ptr == r_cnt - CW'(1)) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_ptr         <= '0;
         r_ovf         <= 1'b0;
         r_frame_count <= '0;
         r_drop_count  <= '0;
         r_err_count   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_err_count <= r_err_count + {30'd0, w_err_inc};
         if (w_take) begin
            r_ptr <= '0;
            if (w_drop) begin
               r_cnt        <= '0;
               r_ovf        <= 1'b0;
               r_drop_count <= r_drop_count + 32'd1;
            end else begin
               r_cnt <= w_push ? w_base_cnt + CW'(1) : w_base_cnt;
               r_ovf <= w_ovf_nxt;
            end
         end
         if (r_state == S_COMMIT) begin
            if (w_done) begin
               r_cnt         <= '0;
               r_ovf         <= 1'b0;
               r_frame_count <= r_frame_count + 32'd1;
            end else begin
               r_ptr <= r_ptr + CW'(1);
            end
         end
      end
   end

   // Staging contents need no reset: r_cnt alone defines what is valid.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_stage_idx[w_base_cnt[PW-1:0]] <= w_addr[IW-1:0];
         r_stage_val[w_base_cnt[PW-1:0]] <= w_val;
      end
   end

   assign w_rd_acc     = rd_en & rd_ready;
   assign w_rd_inrange = ({1'b0, rd_addr} < LP_NREGS);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (w_wr) r_regs[r_stage_idx[r_ptr[PW-1:0]]] <= r_stage_val[r_ptr[PW-1:0]];
         r_rd_valid <= w_rd_acc;
         r_rd_data  <= (w_rd_acc && w_rd_inrange) ? r_regs[rd_addr[IW-1:0]] : '0;
      end
   end

   assign in_ready    = !Rst && (r_state != S_COMMIT);
   assign rd_ready    = !Rst && (r_state != S_COMMIT);
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign frame_count = r_frame_count;
   assign drop_count  = r_drop_count;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_stats_unpacker_avlstrm.sv
// Directed bench for stats_unpacker_avlstrm: frame sequences plus a table of CSR read-backs.
module tb_stats_unpacker_avlstrm;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [39:0] in_data;
   logic        in_valid, in_sop, in_eop, in_ready;
   logic        rd_en, rd_ready, rd_valid;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data, frame_count, drop_count, err_count;

   int checks = 0;
   int errors = 0;

   stats_unpacker_avlstrm dut (
      .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
      .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .frame_count(frame_count),
      .drop_count(drop_count), .err_count(err_count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic sop, input logic eop, input logic [7:0] a, input logic [31:0] v);
      int n;
      in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = {a, v};
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
      step();
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic stall_len(output int n);
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic do_read(input logic [7:0] a, output logic v, output logic [31:0] d);
      int n;
      rd_en = 1'b1; rd_addr = a;
      n = 0;
      while (!rd_ready && n < 50) begin
         step();
         n++;
      end
      step();
      rd_en = 1'b0;
      v = rd_valid;
      d = rd_data;
   endtask

   initial begin
      int          n, cs;
      logic        v;
      logic [31:0] d;

      tbl[0]  = '{8'd2,  32'hAA};
      tbl[1]  = '{8'd5,  32'hBB};
      tbl[2]  = '{8'd70, 32'h0};
      tbl[3]  = '{8'd1,  32'h33};
      tbl[4]  = '{8'h50, 32'h0};
      tbl[5]  = '{8'd10, 32'h0};
      tbl[6]  = '{8'd29, 32'h0};
      tbl[7]  = '{8'd3,  32'h2};
      tbl[8]  = '{8'd7,  32'h9};
      tbl[9]  = '{8'd4,  32'h0};
      tbl[10] = '{8'd6,  32'hB};

      Rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      repeat (3) step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_frame_count", frame_count, 32'd0);
      chk("rst_drop_count", drop_count, 32'd0);
      chk("rst_err_count", err_count, 32'd0);
      Rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_rd_ready", {31'd0, rd_ready}, 32'd1);

      // Three-record frame with a NOTUSED record; read held across the commit.
      send(1'b1, 1'b0, 8'h02, 32'hAA);
      send(1'b0, 1'b0, 8'h05, 32'hBB);
      send(1'b0, 1'b1, 8'hFF, 32'h11);
      rd_en = 1'b1; rd_addr = 8'd5;
      n = 0; cs = 0;
      while (!in_ready && n < 40) begin
         if (rd_ready !== 1'b0) cs++;
         step();
         n++;
      end
      chk("f1_stall_cycles", n, 32'd2);
      chk("f1_rd_ready_during_commit", cs, 32'd0);
      chk("f1_rd_ready_after", {31'd0, rd_ready}, 32'd1);
      step();
      rd_en = 1'b0;
      chk("f1_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("f1_rd_data", rd_data, 32'hBB);
      step();
      chk("f1_rd_valid_drop", {31'd0, rd_valid}, 32'd0);
      chk("f1_frame_count", frame_count, 32'd1);

      send(1'b0, 1'b0, 8'h09, 32'h99);
      chk("nosop_err", err_count, 32'd1);

      send(1'b1, 1'b0, 8'h01, 32'h33);
      send(1'b0, 1'b1, 8'h50, 32'h44);
      stall_len(n);
      chk("badaddr_stall", n, 32'd1);
      chk("badaddr_err", err_count, 32'd2);
      chk("badaddr_frame_count", frame_count, 32'd2);

      // 33 valid records: one past the staging depth.
      for (int i = 0; i < 33; i++)
         send(i == 0, i == 32, 8'(10 + (i % 20)), 32'hD000 + i);
      chk("ovf_in_ready", {31'd0, in_ready}, 32'd1);
      chk("ovf_drop_count", drop_count, 32'd1);
      chk("ovf_frame_count", frame_count, 32'd2);

      send(1'b1, 1'b0, 8'd3, 32'h1);
      send(1'b0, 1'b1, 8'd3, 32'h2);
      stall_len(n);
      chk("dup_stall", n, 32'd2);

      send(1'b1, 1'b1, 8'd7, 32'h9);
      stall_len(n);
      chk("single_stall", n, 32'd1);
      chk("single_frame_count", frame_count, 32'd4);

      send(1'b1, 1'b1, 8'hFF, 32'h5);
      stall_len(n);
      chk("k0_stall", n, 32'd1);
      chk("k0_frame_count", frame_count, 32'd5);

      send(1'b1, 1'b0, 8'd4, 32'hA);
      send(1'b1, 1'b1, 8'd6, 32'hB);
      stall_len(n);
      chk("resop_stall", n, 32'd1);
      chk("resop_err", err_count, 32'd3);
      chk("resop_frame_count", frame_count, 32'd6);

      for (int i = 0; i < 11; i++) begin
         do_read(tbl[i].addr, v, d);
         chk($sformatf("rd_valid[%0d]", tbl[i].addr), {31'd0, v}, 32'd1);
         chk($sformatf("rd_data[%0d]", tbl[i].addr), d, tbl[i].exp);
      end

      // Reset in the middle of a frame.
      send(1'b1, 1'b0, 8'd8, 32'h1);
      send(1'b0, 1'b0, 8'd9, 32'h2);
      Rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_frame_count", frame_count, 32'd0);
      chk("mid_rst_err_count", err_count, 32'd0);
      chk("mid_rst_drop_count", drop_count, 32'd0);
      step();
      Rst = 1'b0;
      #1;
      send(1'b1, 1'b1, 8'd2, 32'h77);
      stall_len(n);
      chk("post_rst_frame_count", frame_count, 32'd1);
      do_read(8'd2, v, d);
      chk("post_rst_rd2", d, 32'h77);
      do_read(8'd5, v, d);
      chk("post_rst_rd5", d, 32'h0);
      do_read(8'd8, v, d);
      chk("post_rst_rd8", d, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
